udma_stream_tx_arbiter: RTL and testbench

Shares one uDMA L2 TX read channel between N_STREAMS requesters, for example several stream units and TX peripherals.
- Request side: round-robin arbitration, forwarding the winner's addr/datasize downstream.
- Response side: an in-order ID FIFO records who owns each granted read, so returned data is routed back to the correct requester.
- Sits between the requesters' tx_ch_* ports and the uDMA TX channel.

---
 rtl/udma_stream_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_udma_stream_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/udma_stream_tx_arbiter.sv
// udma_stream_tx_arbiter
// Shares one uDMA L2 TX read channel between N_STREAMS requesters.
// Requests are arbitrated round-robin and the winner's addr/datasize is
// forwarded downstream. An in-order ID FIFO remembers who owns each granted
// read, so returned data is steered back to the right requester.
//
// Handshakes: a downstream request transfers when tx_ch_req_o and tx_ch_gnt_i
// are both high in the same cycle, and that grant is reflected on gnt_o with
// zero latency. A response transfers when tx_ch_valid_i and tx_ch_ready_o are
// both high. valid_o/ready_i follow the same rule per requester.
//
// Optional build macro: UDMA_STREAM_ARB_LOCK_EN adds lock_i, which lets a
// requester keep the channel for consecutive grants.
module udma_stream_tx_arbiter #(
   parameter int N_STREAMS      = 4,
   parameter int L2_AWIDTH_NOAL = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int OUTSTANDING    = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic                                  cmd_clr_i,
   input  logic [N_STREAMS-1:0]                  req_i,
   input  logic [N_STREAMS*L2_AWIDTH_NOAL-1:0]   addr_i,
   input  logic [N_STREAMS*2-1:0]                datasize_i,
   output logic [N_STREAMS-1:0]                  gnt_o,
   output logic [N_STREAMS-1:0]                  valid_o,
   output logic [DATA_WIDTH-1:0]                 data_o,
   input  logic [N_STREAMS-1:0]                  ready_i,
`ifdef UDMA_STREAM_ARB_LOCK_EN
   input  logic [N_STREAMS-1:0]                  lock_i,
`endif
   output logic                                  tx_ch_req_o,
   output logic [L2_AWIDTH_NOAL-1:0]             tx_ch_addr_o,
   output logic [1:0]                            tx_ch_datasize_o,
   input  logic                                  tx_ch_gnt_i,
   input  logic                                  tx_ch_valid_i,
   input  logic [DATA_WIDTH-1:0]                 tx_ch_data_i,
   output logic                                  tx_ch_ready_o,
   output logic                                  busy_o,
   output logic                                  err_o
);

   localparam int IDW = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;
   localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW  = $clog2(OUTSTANDING + 1);

   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] r_fifo [OUTSTANDING];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_err;

   logic [N_STREAMS-1:0] s_req_mask;
   logic [IDW-1:0]       s_winner;
   logic                 s_found;
   int                   s_idx;
   logic                 s_grant;
   logic                 s_pop;
   logic                 s_fifo_empty;
   logic                 s_fifo_full;
   logic [IDW-1:0]       s_head;
   logic                 s_lock_hold;

`ifdef UDMA_STREAM_ARB_LOCK_EN
   logic           r_lock_valid;
   logic [IDW-1:0] r_lock_id;

   // While locked, only the lock owner is eligible to win.
   always_comb begin
      s_req_mask = req_i;
      if (r_lock_valid)
         s_req_mask = req_i & (N_STREAMS'(1) << r_lock_id);
   end
   assign s_lock_hold = r_lock_valid;
`else
   assign s_req_mask  = req_i;
   assign s_lock_hold = 1'b0;
`endif

   assign s_fifo_empty = (r_count == '0);
   assign s_fifo_full  = (r_count == CW'(OUTSTANDING));
   assign s_head       = r_fifo[r_rd_ptr];

   // Round-robin search starting at r_rr_ptr, wrapping modulo N_STREAMS.
   always_comb begin
      s_winner = '0;
      s_found  = 1'b0;
      s_idx    = 0;
      for (int i = 0; i < N_STREAMS; i++) begin
         s_idx = (int'(r_rr_ptr) + i) % N_STREAMS;
         if (!s_found && s_req_mask[s_idx]) begin
            s_found  = 1'b1;
            s_winner = IDW'(s_idx);
         end
      end
   end

   assign tx_ch_req_o = s_found & ~s_fifo_full & ~cmd_clr_i;
   assign s_grant     = tx_ch_req_o & tx_ch_gnt_i;

   // Forward the winner's address and datasize; zero when nobody requests.
   always_comb begin
      tx_ch_addr_o     = '0;
      tx_ch_datasize_o = '0;
      if (s_found) begin
         tx_ch_addr_o     = addr_i[int'(s_winner)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
         tx_ch_datasize_o = datasize_i[int'(s_winner)*2 +: 2];
      end
   end

   assign gnt_o   = s_grant ? (N_STREAMS'(1) << s_winner) : '0;

   // Response path: the FIFO head owns whatever comes back next.
   assign valid_o       = (tx_ch_valid_i & ~s_fifo_empty) ? (N_STREAMS'(1) << s_head) : '0;
   assign tx_ch_ready_o = ~s_fifo_empty & ready_i[s_head];
   assign s_pop         = tx_ch_valid_i & tx_ch_ready_o;
   assign data_o        = tx_ch_data_i;
   assign busy_o        = ~s_fifo_empty;
   assign err_o         = r_err;

   // Rotation pointer advances past each winner unless a lock is held.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rr_ptr <= '0;
      end else if (cmd_clr_i) begin
         r_rr_ptr <= '0;
      end else if (s_grant && !s_lock_hold) begin
         r_rr_ptr <= (int'(s_winner) == N_STREAMS - 1) ? '0 : s_winner + 1'b1;
      end
   end

`ifdef UDMA_STREAM_ARB_LOCK_EN
   // Lock is taken on a locked grant and dropped on an unlocked grant to the
   // owner, or when the owner stops requesting.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_lock_valid <= 1'b0;
         r_lock_id    <= '0;
      end else if (cmd_clr_i) begin
         r_lock_valid <= 1'b0;
         r_lock_id    <= '0;
      end else if (r_lock_valid) begin
         if ((s_grant && !lock_i[r_lock_id]) || (!req_i[r_lock_id] && !s_grant))
            r_lock_valid <= 1'b0;
      end else if (s_grant && lock_i[s_winner]) begin
         r_lock_valid <= 1'b1;
         r_lock_id    <= s_winner;
      end
   end
`endif

   // ID FIFO pointers and occupancy; a clear empties it outright.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (cmd_clr_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (s_grant)
            r_wr_ptr <= (int'(r_wr_ptr) == OUTSTANDING - 1) ? '0 : r_wr_ptr + 1'b1;
         if (s_pop)
            r_rd_ptr <= (int'(r_rd_ptr) == OUTSTANDING - 1) ? '0 : r_rd_ptr + 1'b1;
         case ({s_grant, s_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ID FIFO storage: record the winner of every grant.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < OUTSTANDING; i++)
            r_fifo[i] <= '0;
      end else if (s_grant && !cmd_clr_i) begin
         r_fifo[r_wr_ptr] <= s_winner;
      end
   end

   // Sticky error: a response showed up with no owner on record.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_err <= 1'b0;
      end else if (cmd_clr_i) begin
         r_err <= 1'b0;
      end else if (tx_ch_valid_i && s_fifo_empty) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_udma_stream_tx_arbiter.sv
// Directed bench for udma_stream_tx_arbiter (default build, no lock).
module tb_udma_stream_tx_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic            clk_i = 1'b0;
   logic            rstn_i;
   logic            cmd_clr_i;
   logic [N-1:0]    req_i;
   logic [N*AW-1:0] addr_i;
   logic [N*2-1:0]  datasize_i;
   logic [N-1:0]    gnt_o;
   logic [N-1:0]    valid_o;
   logic [DW-1:0]   data_o;
   logic [N-1:0]    ready_i;
   logic            tx_ch_req_o;
   logic [AW-1:0]   tx_ch_addr_o;
   logic [1:0]      tx_ch_datasize_o;
   logic            tx_ch_gnt_i;
   logic            tx_ch_valid_i;
   logic [DW-1:0]   tx_ch_data_i;
   logic            tx_ch_ready_o;
   logic            busy_o;
   logic            err_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [N-1:0]  req;
      logic          tgnt;
      logic          tval;
      logic [DW-1:0] tdata;
      logic [N-1:0]  rdy;
      logic          clr;
      logic [N-1:0]  e_gnt;
      logic [N-1:0]  e_val;
      logic          e_treq;
      logic          e_trdy;
      logic          e_busy;
      logic          e_err;
      int            e_win;
   } vec_t;

   vec_t vq[$];

   // clock / reset
   always #5 clk_i = ~clk_i;

   udma_stream_tx_arbiter #(
      .N_STREAMS(N), .L2_AWIDTH_NOAL(AW), .DATA_WIDTH(DW), .OUTSTANDING(2)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .cmd_clr_i(cmd_clr_i),
      .req_i(req_i), .addr_i(addr_i), .datasize_i(datasize_i),
      .gnt_o(gnt_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
      .tx_ch_req_o(tx_ch_req_o), .tx_ch_addr_o(tx_ch_addr_o),
      .tx_ch_datasize_o(tx_ch_datasize_o), .tx_ch_gnt_i(tx_ch_gnt_i),
      .tx_ch_valid_i(tx_ch_valid_i), .tx_ch_data_i(tx_ch_data_i),
      .tx_ch_ready_o(tx_ch_ready_o), .busy_o(busy_o), .err_o(err_o)
   );

   function automatic logic [AW-1:0] exp_addr(int k);
      return AW'(16'h1000 + k * 16'h0111);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [N-1:0] req, logic tgnt, logic tval, logic [DW-1:0] tdata,
                        logic [N-1:0] rdy, logic clr);
      req_i         = req;
      tx_ch_gnt_i   = tgnt;
      tx_ch_valid_i = tval;
      tx_ch_data_i  = tdata;
      ready_i       = rdy;
      cmd_clr_i     = clr;
   endtask

   task automatic add(logic [N-1:0] req, logic tgnt, logic tval, logic [DW-1:0] tdata,
                      logic [N-1:0] rdy, logic clr, logic [N-1:0] e_gnt, logic [N-1:0] e_val,
                      logic e_treq, logic e_trdy, logic e_busy, logic e_err, int e_win);
      vq.push_back('{req, tgnt, tval, tdata, rdy, clr,
                     e_gnt, e_val, e_treq, e_trdy, e_busy, e_err, e_win});
   endtask

   initial begin
      // vector table: inputs then expected outputs observed within that cycle
      //   req     g  v  data          rdy     c   gnt      val      treq trdy busy err win
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      // all request, downstream grants every cycle: 0, 1, then FIFO full
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 0, 4'b0001, 4'b0000, 1, 0, 0, 0,  0);
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 0, 4'b0010, 4'b0000, 1, 0, 1, 0,  1);
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,  2);
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1, 0,  2);
      // drain IDs 0 then 1
      add(4'b0000, 0, 1, 32'hA5A5A5A5, 4'b1111, 0, 4'b0000, 4'b0001, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 1, 32'h5A5A5A5A, 4'b1111, 0, 4'b0000, 4'b0010, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      // grants to 2 then 0 (pointer at 2), responses routed back in order
      add(4'b0101, 1, 0, 32'h0,        4'b0000, 0, 4'b0100, 4'b0000, 1, 0, 0, 0,  2);
      add(4'b0101, 1, 0, 32'h0,        4'b0000, 0, 4'b0001, 4'b0000, 1, 0, 1, 0,  0);
      add(4'b0000, 0, 1, 32'hA5A5A5A5, 4'b1111, 0, 4'b0000, 4'b0100, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 1, 32'h5A5A5A5A, 4'b1111, 0, 4'b0000, 4'b0001, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      // back-pressure: owner 2 holds ready low for 3 cycles, then one pop
      add(4'b0100, 1, 0, 32'h0,        4'b0000, 0, 4'b0100, 4'b0000, 1, 0, 0, 0,  2);
      add(4'b0000, 0, 1, 32'h11111111, 4'b1011, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, -1);
      add(4'b0000, 0, 1, 32'h11111111, 4'b1011, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, -1);
      add(4'b0000, 0, 1, 32'h11111111, 4'b1011, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, -1);
      add(4'b0000, 0, 1, 32'h11111111, 4'b1111, 0, 4'b0000, 4'b0100, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      // push and pop in the same cycle (pointer at 3)
      add(4'b1000, 1, 0, 32'h0,        4'b0000, 0, 4'b1000, 4'b0000, 1, 0, 0, 0,  3);
      add(4'b0010, 1, 1, 32'h22222222, 4'b1111, 0, 4'b0010, 4'b1000, 1, 1, 1, 0,  1);
      add(4'b0000, 0, 1, 32'h33333333, 4'b1111, 0, 4'b0000, 4'b0010, 0, 1, 1, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      // response while empty: sticky error
      add(4'b0000, 0, 1, 32'hDEADBEEF, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, -1);
      add(4'b0010, 1, 0, 32'h0,        4'b0000, 0, 4'b0010, 4'b0000, 1, 0, 0, 1,  1);
      // clear: request suppressed, then FIFO/pointer/error reset
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1, 1,  2);
      add(4'b1111, 1, 0, 32'h0,        4'b0000, 0, 4'b0001, 4'b0000, 1, 0, 0, 0,  0);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1, 0, -1);
      add(4'b0000, 0, 0, 32'h0,        4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1);
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         addr_i[k*AW +: AW]   = exp_addr(k);
         datasize_i[k*2 +: 2] = 2'(k);
      end
      rstn_i = 1'b0;
      drive('0, 0, 0, '0, '0, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_gnt", 64'(gnt_o), 0);
      check("rst_valid", 64'(valid_o), 0);
      check("rst_req", 64'(tx_ch_req_o), 0);
      check("rst_ready", 64'(tx_ch_ready_o), 0);
      check("rst_busy", 64'(busy_o), 0);
      check("rst_err", 64'(err_o), 0);
      check("rst_addr", 64'(tx_ch_addr_o), 0);
      @(posedge clk_i);
      #1 rstn_i = 1'b1;

      // table-driven phase
      foreach (vq[i]) begin
         vec_t v;
         v = vq[i];
         @(posedge clk_i);
         #1 drive(v.req, v.tgnt, v.tval, v.tdata, v.rdy, v.clr);
         @(negedge clk_i);
         check($sformatf("v%0d_gnt", i), 64'(gnt_o), 64'(v.e_gnt));
         check($sformatf("v%0d_valid", i), 64'(valid_o), 64'(v.e_val));
         check($sformatf("v%0d_req", i), 64'(tx_ch_req_o), 64'(v.e_treq));
         check($sformatf("v%0d_ready", i), 64'(tx_ch_ready_o), 64'(v.e_trdy));
         check($sformatf("v%0d_busy", i), 64'(busy_o), 64'(v.e_busy));
         check($sformatf("v%0d_err", i), 64'(err_o), 64'(v.e_err));
         check($sformatf("v%0d_data", i), 64'(data_o), 64'(v.tdata));
         if (v.e_win >= 0) begin
            check($sformatf("v%0d_addr", i), 64'(tx_ch_addr_o), 64'(exp_addr(v.e_win)));
            check($sformatf("v%0d_dsize", i), 64'(tx_ch_datasize_o), 64'(v.e_win % 4));
         end else begin
            check($sformatf("v%0d_addr", i), 64'(tx_ch_addr_o), 0);
         end
      end

      // async reset mid-transaction: fill the FIFO, then reset between edges
      @(posedge clk_i);
      #1 drive(4'b1111, 1, 0, '0, '0, 0);
      @(negedge clk_i);
      check("ar_gnt0", 64'(gnt_o), 64'(4'b0001));
      @(posedge clk_i);
      #1;
      check("ar_busy_before", 64'(busy_o), 1);
      @(posedge clk_i);
      #1 drive('0, 0, 0, '0, '0, 0);
      #1;
      check("ar_full_busy", 64'(busy_o), 1);
      #1 rstn_i = 1'b0;
      #1;
      check("ar_busy_in_reset", 64'(busy_o), 0);
      check("ar_req_in_reset", 64'(tx_ch_req_o), 0);
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
      drive(4'b1111, 1, 0, '0, '0, 0);
      @(negedge clk_i);
      check("ar_gnt_after", 64'(gnt_o), 64'(4'b0001));
      check("ar_busy_after", 64'(busy_o), 0);
      @(posedge clk_i);
      #1 drive('0, 0, 0, '0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
